// File: rtl/ps2_keypad_rx.sv
// PS/2 keyboard receiver: conditions the raw lines, deframes 11-bit frames
// and turns W/A/S/D and extended arrow make/break codes into held-key levels.
module ps2_keypad_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p1_left,
    output logic       p1_right,
    output logic       p2_up,
    output logic       p2_down,
    output logic       p2_left,
    output logic       p2_right
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_nx;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic          clk_prev;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          bit_in;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic          frame_ok;
    logic          frame_bad;
    logic          brk;
    logic          ext;

    assign bit_in  = dat_sync[1];
    assign fall    = clk_prev & ~clk_filt;
    assign timeout = (state != IDLE) && !fall && (tcnt == TLAST);

    // The filtered clock only moves after a sustained disagreement.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            clk_prev <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FLAST) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (timeout) begin
            state_nx  = IDLE;
            frame_bad = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!bit_in) state_nx = DATA;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) state_nx = PARITY;
                end
                PARITY: state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    // Odd parity: data bits plus parity bit must XOR to 1.
                    if (bit_in && (^shift ^ par_bit)) frame_ok = 1'b1;
                    else frame_bad = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tcnt     <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= frame_ok;
            rx_err   <= frame_bad;
            if (frame_ok) rx_data <= shift;
            if (state == IDLE || fall || timeout) tcnt <= '0;
            else tcnt <= tcnt + 1'b1;
            if (fall) begin
                if (state == IDLE) bit_cnt <= '0;
                if (state == DATA) begin
                    shift   <= {bit_in, shift[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (state == PARITY) par_bit <= bit_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            brk      <= 1'b0;
            ext      <= 1'b0;
            p1_up    <= 1'b0;
            p1_down  <= 1'b0;
            p1_left  <= 1'b0;
            p1_right <= 1'b0;
            p2_up    <= 1'b0;
            p2_down  <= 1'b0;
            p2_left  <= 1'b0;
            p2_right <= 1'b0;
        end else if (rx_err) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (rx_valid) begin
            case (rx_data)
                8'hF0: brk <= 1'b1;
                8'hE0: ext <= 1'b1;
                default: begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (!ext) begin
                        case (rx_data)
                            8'h1D:   p1_up    <= !brk;
                            8'h1B:   p1_down  <= !brk;
                            8'h1C:   p1_left  <= !brk;
                            8'h23:   p1_right <= !brk;
                            default: ;
                        endcase
                    end else begin
                        case (rx_data)
                            8'h75:   p2_up    <= !brk;
                            8'h72:   p2_down  <= !brk;
                            8'h6B:   p2_left  <= !brk;
                            8'h74:   p2_right <= !brk;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_keypad_rx.sv
// Bench for ps2_keypad_rx: directed frame table, timeout/glitch/reset
// sequences and randomized frames checked against a key-state model.
module tb_ps2_keypad_rx;
    localparam int FLT = 8;
    localparam int TMO = 2000;
    localparam int H   = 30;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       p1_up, p1_down, p1_left, p1_right;
    logic       p2_up, p2_down, p2_left, p2_right;
    logic [7:0] keys;

    ps2_keypad_rx #(
        .FILTER_LEN    (FLT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_err  (rx_err),
        .p1_up   (p1_up),
        .p1_down (p1_down),
        .p1_left (p1_left),
        .p1_right(p1_right),
        .p2_up   (p2_up),
        .p2_down (p2_down),
        .p2_left (p2_left),
        .p2_right(p2_right)
    );

    assign keys = {p1_up, p1_down, p1_left, p1_right,
                   p2_up, p2_down, p2_left, p2_right};

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       par_ok;
        logic       stop_ok;
        logic       exp_v;
        logic [7:0] exp_data;
        logic [7:0] exp_keys;
    } vec_t;

    vec_t tbl[$];

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    int vcnt = 0;
    int ecnt = 0;
    int overlap = 0;
    int wide = 0;
    int last_err_cyc = 0;
    int fall_cyc = 0;
    logic pv = 1'b0;
    logic pe = 1'b0;

    logic [7:0] p1_codes [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    logic [7:0] p2_codes [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] m_keys = 8'h00;
    logic [7:0] m_rx = 8'h00;
    logic       m_brk = 1'b0;
    logic       m_ext = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid) vcnt <= vcnt + 1;
        if (rx_err) begin
            ecnt <= ecnt + 1;
            last_err_cyc <= cyc;
        end
        if (rx_valid && rx_err) overlap <= overlap + 1;
        if ((rx_valid && pv) || (rx_err && pe)) wide <= wide + 1;
        pv <= rx_valid;
        pe <= rx_err;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    function automatic logic [10:0] build(input logic [7:0] b,
                                          input logic pok, input logic sok);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = (~^b) ^ !pok;
        f[10]  = sok;
        return f;
    endfunction

    task automatic send_bit(input logic b, input bit glitch);
        repeat (H/2) @(posedge clk);
        ps2_data = b;
        if (glitch) begin
            repeat (2) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (5) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (H/2 - 7) @(posedge clk);
        end else begin
            repeat (H/2) @(posedge clk);
        end
        ps2_clk = 1'b0;
        fall_cyc = cyc;
        repeat (H) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_range(input logic [10:0] f, input int lo,
                              input int hi, input int gl);
        for (int i = lo; i <= hi; i++) send_bit(f[i], i == gl);
    endtask

    task automatic run_frame(input string nm, input logic [7:0] b,
                             input logic pok, input logic sok, input int gl,
                             input logic ev, input logic [7:0] ed,
                             input logic [7:0] ek);
        int v0;
        int e0;
        v0 = vcnt;
        e0 = ecnt;
        send_range(build(b, pok, sok), 0, 10, gl);
        ps2_data = 1'b1;
        repeat (2*H) @(posedge clk);
        @(negedge clk);
        check({nm, " valid"}, vcnt - v0, 32'(ev));
        check({nm, " err"}, ecnt - e0, 32'(!ev));
        check({nm, " data"}, 32'(rx_data), 32'(ed));
        check({nm, " keys"}, 32'(keys), 32'(ek));
    endtask

    task automatic model_frame(input logic [7:0] b, input logic ok);
        if (!ok) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            m_rx = b;
            if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else if (b == 8'hE0) begin
                m_ext = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (!m_ext && b == p1_codes[k]) m_keys[7-k] = !m_brk;
                    if (m_ext && b == p2_codes[k]) m_keys[3-k] = !m_brk;
                end
                m_brk = 1'b0;
                m_ext = 1'b0;
            end
        end
    endtask

    initial begin
        logic [10:0] f;
        logic [7:0]  b;
        logic        pok;
        logic        sok;
        int          r;
        int          v0;
        int          e0;
        int          lat;

        tbl.push_back({8'h1D, 1'b1, 1'b1, 1'b1, 8'h1D, 8'h80});
        tbl.push_back({8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 8'h80});
        tbl.push_back({8'h1D, 1'b1, 1'b1, 1'b1, 8'h1D, 8'h00});
        tbl.push_back({8'hE0, 1'b1, 1'b1, 1'b1, 8'hE0, 8'h00});
        tbl.push_back({8'h75, 1'b1, 1'b1, 1'b1, 8'h75, 8'h08});
        tbl.push_back({8'hE0, 1'b1, 1'b1, 1'b1, 8'hE0, 8'h08});
        tbl.push_back({8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 8'h08});
        tbl.push_back({8'h75, 1'b1, 1'b1, 1'b1, 8'h75, 8'h00});
        tbl.push_back({8'h1D, 1'b1, 1'b1, 1'b1, 8'h1D, 8'h80});
        tbl.push_back({8'h1C, 1'b0, 1'b1, 1'b0, 8'h1D, 8'h80});
        tbl.push_back({8'h1C, 1'b1, 1'b1, 1'b1, 8'h1C, 8'hA0});
        tbl.push_back({8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 8'hA0});
        tbl.push_back({8'h1C, 1'b1, 1'b1, 1'b1, 8'h1C, 8'h80});
        tbl.push_back({8'hE0, 1'b1, 1'b1, 1'b1, 8'hE0, 8'h80});
        tbl.push_back({8'h6B, 1'b1, 1'b1, 1'b1, 8'h6B, 8'h82});
        tbl.push_back({8'h2A, 1'b1, 1'b1, 1'b1, 8'h2A, 8'h82});
        tbl.push_back({8'h72, 1'b1, 1'b1, 1'b1, 8'h72, 8'h82});
        tbl.push_back({8'hE0, 1'b1, 1'b1, 1'b1, 8'hE0, 8'h82});
        tbl.push_back({8'h1B, 1'b1, 1'b1, 1'b1, 8'h1B, 8'h82});
        tbl.push_back({8'h1B, 1'b1, 1'b0, 1'b0, 8'h1B, 8'h82});
        tbl.push_back({8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 8'h82});
        tbl.push_back({8'h6B, 1'b0, 1'b1, 1'b0, 8'hF0, 8'h82});
        tbl.push_back({8'hE0, 1'b1, 1'b1, 1'b1, 8'hE0, 8'h82});
        tbl.push_back({8'h6B, 1'b1, 1'b1, 1'b1, 8'h6B, 8'h82});
        tbl.push_back({8'hE0, 1'b1, 1'b1, 1'b1, 8'hE0, 8'h82});
        tbl.push_back({8'h72, 1'b1, 1'b1, 1'b1, 8'h72, 8'h86});
        tbl.push_back({8'hE0, 1'b1, 1'b1, 1'b1, 8'hE0, 8'h86});
        tbl.push_back({8'h74, 1'b1, 1'b1, 1'b1, 8'h74, 8'h87});
        tbl.push_back({8'h1C, 1'b1, 1'b1, 1'b1, 8'h1C, 8'hA7});
        tbl.push_back({8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 8'hA7});
        tbl.push_back({8'hE0, 1'b1, 1'b1, 1'b1, 8'hE0, 8'hA7});
        tbl.push_back({8'h72, 1'b1, 1'b1, 1'b1, 8'h72, 8'hA3});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset data", 32'(rx_data), 32'h0);
        check("reset keys", 32'(keys), 32'h0);
        check("reset pulses", 32'({rx_valid, rx_err}), 32'h0);
        @(posedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            run_frame($sformatf("row%0d", i), tbl[i].code, tbl[i].par_ok,
                      tbl[i].stop_ok, -1, tbl[i].exp_v, tbl[i].exp_data,
                      tbl[i].exp_keys);
        end
        m_keys = 8'hA3;
        m_rx = 8'h72;

        v0 = vcnt;
        e0 = ecnt;
        send_range(build(8'h55, 1'b1, 1'b1), 0, 4, -1);
        repeat (2500) @(posedge clk);
        @(negedge clk);
        check("timeout err count", ecnt - e0, 32'd1);
        check("timeout no valid", vcnt - v0, 32'd0);
        lat = last_err_cyc - fall_cyc;
        check("timeout latency", 32'(lat >= TMO && lat <= TMO + 40), 32'd1);
        model_frame(8'h00, 1'b0);
        model_frame(8'h23, 1'b1);
        run_frame("after timeout", 8'h23, 1'b1, 1'b1, -1, 1'b1, m_rx, m_keys);

        v0 = vcnt;
        e0 = ecnt;
        ps2_clk = 1'b0;
        repeat (5) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (3*H) @(posedge clk);
        @(negedge clk);
        check("idle glitch pulses", (vcnt - v0) + (ecnt - e0), 32'd0);
        model_frame(8'h1B, 1'b1);
        run_frame("glitch frame", 8'h1B, 1'b1, 1'b1, 4, 1'b1, m_rx, m_keys);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'hF0;
            else if (r == 2) b = 8'hE0;
            else if (r < 5) b = p1_codes[$urandom_range(0, 3)];
            else if (r < 7) b = p2_codes[$urandom_range(0, 3)];
            else b = 8'($urandom);
            pok = 1'b1;
            sok = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) pok = 1'b0;
                else sok = 1'b0;
            end
            model_frame(b, pok & sok);
            run_frame($sformatf("rand%0d", n), b, pok, sok, -1, pok & sok,
                      m_rx, m_keys);
        end

        f = build(8'h1D, 1'b1, 1'b1);
        send_range(f, 0, 8, -1);
        repeat (3) @(posedge clk);
        reset = 1'b1;
        @(posedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midreset data", 32'(rx_data), 32'h0);
        check("midreset keys", 32'(keys), 32'h0);
        v0 = vcnt;
        e0 = ecnt;
        send_range(f, 9, 10, -1);
        ps2_data = 1'b1;
        repeat (2*H) @(posedge clk);
        @(negedge clk);
        check("midreset tail valid", vcnt - v0, 32'd0);
        check("midreset tail err", ecnt - e0, 32'd0);
        run_frame("post reset E0", 8'hE0, 1'b1, 1'b1, -1, 1'b1, 8'hE0, 8'h00);
        run_frame("post reset 74", 8'h74, 1'b1, 1'b1, -1, 1'b1, 8'h74, 8'h01);

        check("valid/err overlap", overlap, 32'd0);
        check("pulse width", wide, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/ps2_keypad_rx.md
Name: ps2_keypad_rx

Overview:
- PS/2 device-to-host receiver that feeds the game input side of the VGA display path, replacing the board-button movement inputs.
- Samples the keyboard's ps2_clk/ps2_data lines, deframes 11-bit frames, and checks parity and stop bits.
- Decodes make/break scan codes, including the E0 extended and F0 break prefixes.
- Outputs level "key held" signals: p1_* from W/A/S/D and p2_* from the arrow keys. These drive the paddle movement logic directly.

Parameters:
- FILTER_LEN, 8: consecutive stable clk cycles required before the filtered ps2_clk follows the raw line.
- TIMEOUT_CYCLES, 200000: clk cycles (2 ms at 100 MHz) allowed between falling edges inside a frame before the frame is abandoned.

Ports:
- clk  input  1  100 MHz system clock.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock line (top level holds the inout at Z).
- ps2_data  input  1  raw PS/2 data line.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse; rx_data is valid on this cycle.
- rx_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.
- p1_up, p1_down, p1_left, p1_right  output  1 each  held state of W (0x1D), S (0x1B), A (0x1C), D (0x23).
- p2_up, p2_down, p2_left, p2_right  output  1 each  held state of E0-prefixed 0x75, 0x72, 0x6B, 0x74.

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE.
  - brk and ext flags 0; bit and timeout counters 0.
  - Filtered clock and synchronizer flops preset to 1 (lines idle high).
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - The filtered clock takes the synchronized value only after it has differed from the filtered value for FILTER_LEN consecutive cycles. Shorter glitches are ignored.
  - Falling edge = filtered clock was 1 on the previous cycle and is 0 now.
  - Synchronized data is sampled on the edge-detect cycle.
- FSM (all transitions happen only on a falling edge, except the timeout):
  - IDLE: data 0 -> DATA with bit count 0. Data 1 -> stay in IDLE, no error.
  - DATA: shift in LSB first, 8 edges total, then -> PARITY.
  - PARITY: latch the parity bit, -> STOP.
  - STOP: if stop bit = 1 and (XOR of the 8 data bits XOR parity) = 1, load rx_data and pulse rx_valid on the next cycle. Otherwise pulse rx_err on the next cycle and leave rx_data unchanged. Always -> IDLE.
- Timeout:
  - In any state other than IDLE, the counter increments each cycle and clears on each falling edge.
  - Reaching TIMEOUT_CYCLES -> IDLE, rx_err pulse, partial data discarded.
  - The counter is held at 0 in IDLE.
- rx_valid and rx_err are never asserted together. Each lasts exactly one cycle.
- Decoder (acts on the cycle after the rx_valid pulse):
  - 0xF0 sets brk.
  - 0xE0 sets ext.
  - Any other byte: if it matches a mapped code with the matching ext state (p1 codes need ext=0, p2 codes need ext=1), the corresponding output <= !brk. Then brk and ext clear, whether or not the code matched.
  - Unmapped codes change no outputs.
  - rx_err clears brk and ext and leaves held outputs unchanged.
- Held outputs are independent. Any combination, including opposing directions, is legal.
- Reset mid-frame returns to IDLE immediately. A frame already in progress is then ignored until a start bit is seen on a later falling edge; no error pulse is produced.

Test Plan:
- Bench drives a 15 kHz PS/2 clock (half-period 3333 cycles) and changes data at mid-high.
- Frame 0x1D (start 0, bits 1,0,1,1,1,0,0,0, parity 1, stop 1) -> rx_data=0x1D, a single one-cycle rx_valid, p1_up=1 one cycle later; all other key outputs 0.
- Bytes F0,1D after the above -> p1_up=0. Then E0,75 -> p2_up=1, p1_up stays 0. Then E0,F0,75 -> p2_up=0; brk and ext are 0 afterwards.
- Frame 0x1C with parity bit 0 -> rx_err pulse, no rx_valid, rx_data unchanged, p1_left stays 0. A following good 0x1C -> p1_left=1.
- Start bit plus 4 data bits, then lines held high for 250000 cycles -> exactly one rx_err about 200000 cycles after the last edge. A following good 0x23 -> rx_data=0x23, p1_right=1.
- A 5-cycle low glitch on ps2_clk while in IDLE and inside a frame -> no state change; a good 0x1B -> p1_down=1. Reset asserted for 1 cycle mid-frame -> all outputs 0, and the next complete frame decodes correctly.
